// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end: NOP encoding, PC reset/step values
// and the fetch-stage FSM state encoding.
package cpu_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load-target takes priority over increment; with
// neither requested the PC holds. PC+4 is exported for the IF/ID latch.
module pc_reg
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_load,
    input  logic        i_inc,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
);

    logic [31:0] r_pc;

    // Increment wraps modulo 2^32, so 32'hFFFF_FFFC steps to 0.
    assign o_pc4 = r_pc + PC_STEP;
    assign o_pc  = r_pc;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc <= PC_RESET;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= o_pc4;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register with IDLE/RUN control.
// Optional saturating stall/flush counters are enabled by macro IF_PERF_CNT_EN.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_mem_i,
    output logic [31:0] if_id_inst_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_inst;
    logic [31:0]  r_pc4;
    logic         r_valid;

    logic         w_fetch;
    logic         w_pc_load;
    logic         w_pc_inc;
    logic [31:0]  w_pc4;

    generate
        if (CNT_W < 1) begin : g_cnt_w_invalid
        end
    endgenerate

    // PC moves only in an active RUN cycle that is not stalled.
    assign w_fetch   = (r_state == RUN) && start_i && !stall_i;
    assign w_pc_load = w_fetch && flush_i;
    assign w_pc_inc  = w_fetch && !flush_i;

    pc_reg u_pc_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (w_pc_load),
        .i_inc    (w_pc_inc),
        .i_target (target_i),
        .o_pc     (pc_o),
        .o_pc4    (w_pc4)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_inst  <= NOP;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_inst  <= NOP;
                    r_pc4   <= 32'h0;
                    r_valid <= 1'b0;
                    if (start_i) r_state <= RUN;
                end
                RUN: begin
                    if (!start_i) begin
                        r_state <= IDLE;
                        r_inst  <= NOP;
                        r_pc4   <= 32'h0;
                        r_valid <= 1'b0;
                    end else if (stall_i) begin
                        // Hold: the ID instruction is unresolved, so a flush is ignored.
                    end else if (flush_i) begin
                        r_inst  <= NOP;
                        r_pc4   <= 32'h0;
                        r_valid <= 1'b0;
                    end else begin
                        r_inst  <= inst_mem_i;
                        r_pc4   <= w_pc4;
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_id_inst_o  = r_inst;
    assign if_id_pc4_o   = r_pc4;
    assign if_id_valid_o = r_valid;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state == RUN) begin
            if (stall_i && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_i && !stall_i && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, async-reset and
// counter sequences (counters only when IF_PERF_CNT_EN is defined), random run vs model.
module tb_if_id_stage;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] target_i;
    logic [31:0] pc_o;
    logic [31:0] inst_mem_i;
    logic [31:0] if_id_inst_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
`ifdef IF_PERF_CNT_EN
    logic [3:0]  stall_cnt_o;
    logic [3:0]  flush_cnt_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    if_id_stage #(.CNT_W(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .target_i      (target_i),
        .pc_o          (pc_o),
        .inst_mem_i    (inst_mem_i),
        .if_id_inst_o  (if_id_inst_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instruction memory contents: 0x8C01_0000 at address 0, distinct elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h8C01_0000 ^ (a * 32'h0001_0003);
    endfunction

    assign inst_mem_i = mem_fn(pc_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic valid);
        check({tag, ".pc"},    pc_o,          pc);
        check({tag, ".inst"},  if_id_inst_o,  inst);
        check({tag, ".pc4"},   if_id_pc4_o,   pc4);
        check({tag, ".valid"}, {31'h0, if_id_valid_o}, {31'h0, valid});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic st, input logic sl, input logic fl, input logic [31:0] tg);
        start_i  = st;
        stall_i  = sl;
        flush_i  = fl;
        target_i = tg;
    endtask

    task automatic reset_dut();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1 rst_i = 1'b0;
        #3 rst_i = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        start;
        logic        stall;
        logic        flush;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic st, input logic sl, input logic fl, input logic [31:0] tg,
                                input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] pc4, input logic valid);
        vec_t v;
        v.start = st; v.stall = sl; v.flush = fl; v.target = tg;
        v.pc = pc; v.inst = inst; v.pc4 = pc4; v.valid = valid;
        return v;
    endfunction

    // Reference model state: run flag, PC and IF/ID contents.
    logic        m_run;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;

    task automatic model_step(input logic st, input logic sl, input logic fl, input logic [31:0] tg);
        if (!m_run || !st) begin
            m_run   = st;
            m_inst  = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (sl) begin
            // everything holds
        end else if (fl) begin
            m_pc    = tg;
            m_inst  = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else begin
            m_inst  = mem_fn(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        vecs[0]  = mk(1, 0, 0, 32'h0,         32'h0,         32'h0,                32'h0,  0);
        vecs[1]  = mk(1, 0, 0, 32'h0,         32'h4,         mem_fn(32'h0),        32'h4,  1);
        vecs[2]  = mk(1, 0, 0, 32'h0,         32'h8,         mem_fn(32'h4),        32'h8,  1);
        vecs[3]  = mk(1, 0, 0, 32'h0,         32'hC,         mem_fn(32'h8),        32'hC,  1);
        vecs[4]  = mk(1, 0, 0, 32'h0,         32'h10,        mem_fn(32'hC),        32'h10, 1);
        vecs[5]  = mk(1, 1, 0, 32'h0,         32'h10,        mem_fn(32'hC),        32'h10, 1);
        vecs[6]  = mk(1, 1, 0, 32'h0,         32'h10,        mem_fn(32'hC),        32'h10, 1);
        vecs[7]  = mk(1, 0, 0, 32'h0,         32'h14,        mem_fn(32'h10),       32'h14, 1);
        vecs[8]  = mk(1, 0, 1, 32'h40,        32'h40,        32'h0,                32'h0,  0);
        vecs[9]  = mk(1, 0, 0, 32'h0,         32'h44,        mem_fn(32'h40),       32'h44, 1);
        vecs[10] = mk(1, 1, 1, 32'h80,        32'h44,        mem_fn(32'h40),       32'h44, 1);
        vecs[11] = mk(1, 0, 1, 32'h80,        32'h80,        32'h0,                32'h0,  0);
        vecs[12] = mk(1, 0, 0, 32'h0,         32'h84,        mem_fn(32'h80),       32'h84, 1);
        vecs[13] = mk(1, 0, 1, 32'h33,        32'h33,        32'h0,                32'h0,  0);
        vecs[14] = mk(1, 0, 0, 32'h0,         32'h37,        mem_fn(32'h33),       32'h37, 1);
        vecs[15] = mk(0, 0, 0, 32'h0,         32'h37,        32'h0,                32'h0,  0);
        vecs[16] = mk(0, 0, 0, 32'h0,         32'h37,        32'h0,                32'h0,  0);
        vecs[17] = mk(1, 0, 0, 32'h0,         32'h37,        32'h0,                32'h0,  0);
        vecs[18] = mk(1, 0, 0, 32'h0,         32'h3B,        mem_fn(32'h37),       32'h3B, 1);
        vecs[19] = mk(1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,                32'h0,  0);
        vecs[20] = mk(1, 0, 0, 32'h0,         32'h0,         mem_fn(32'hFFFF_FFFC), 32'h0, 1);
        vecs[21] = mk(1, 0, 0, 32'h0,         32'h4,         mem_fn(32'h0),        32'h4,  1);

        // Reset values and IDLE hold.
        reset_dut();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check_all("idle_hold", 32'h0, 32'h0, 32'h0, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].start, vecs[i].stall, vecs[i].flush, vecs[i].target);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].pc4, vecs[i].valid);
        end

        // Asynchronous reset in the middle of RUN at PC 0x20.
        reset_dut();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) tick();
        check("arst.pre_pc", pc_o, 32'h20);
        #2 rst_i = 1'b0;
        #1 check_all("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        #2 rst_i = 1'b1;
        tick();
        check("arst.step0", pc_o, 32'h0);
        tick();
        check("arst.step4", pc_o, 32'h4);
        tick();
        check("arst.step8", pc_o, 32'h8);

`ifdef IF_PERF_CNT_EN
        // Counter saturation and flush counting with CNT_W=4.
        reset_dut();
        check("cnt.stall_rst", {28'h0, stall_cnt_o}, 32'h0);
        check("cnt.flush_rst", {28'h0, flush_cnt_o}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("cnt.stall_sat", {28'h0, stall_cnt_o}, 32'd15);
        drive(1'b1, 1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) tick();
        check("cnt.flush3", {28'h0, flush_cnt_o}, 32'd3);
        drive(1'b0, 1'b1, 1'b1, 32'h100);
        tick();
        tick();
        check("cnt.idle_hold", {28'h0, flush_cnt_o}, 32'd3);
`endif

        // Randomized run against the behavioural model.
        reset_dut();
        m_run = 1'b0; m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic        st, sl, fl;
            logic [31:0] tg;
            st = ($urandom_range(0, 19) != 0);
            sl = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 4) == 0);
            tg = $urandom;
            if ($urandom_range(0, 1) == 1) tg[1:0] = 2'b00;
            drive(st, sl, fl, tg);
            model_step(st, sl, fl, tg);
            tick();
            check_all($sformatf("rnd%0d", i), m_pc, m_inst, m_pc4, m_valid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register of the five-stage MIPS core. Owns the PC and fetches from instruction memory. Latches the fetched instruction and PC+4 into IF/ID. Obeys the hold request from the load-use hazard detector and the flush/redirect request from branch/jump resolution in ID. Its IF/ID outputs feed the decode stage, which in turn feeds the hazard detector.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters. Used only when the counter macro is defined.

Ports:
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: reset. Asynchronous, active-low.
- `start_i` input 1: run enable from the testbench/top. Level-sensitive; sampled each cycle.
- `stall_i` input 1: hold request from the hazard detector (the OR of its PC-hold and IF/ID-hold outputs).
- `flush_i` input 1: branch taken or jump in ID.
- `target_i` input 32: redirect PC. Valid when `flush_i`=1.
- `pc_o` output 32: current PC, driven to instruction memory address.
- `inst_mem_i` input 32: instruction memory read data. Combinational from `pc_o`, same cycle.
- `if_id_inst_o` output 32: IF/ID instruction.
- `if_id_pc4_o` output 32: IF/ID PC+4.
- `if_id_valid_o` output 1: IF/ID holds a real (non-bubble) instruction.
- `stall_cnt_o` output CNT_W: stall cycles counted. Present only with the counter macro.
- `flush_cnt_o` output CNT_W: flushes counted. Present only with the counter macro.

## Operation
FSM states:
- **IDLE**: entered on reset.
  - PC frozen; IF/ID loads NOP with valid=0.
  - Moves to RUN on the first rising edge where `start_i`=1.
- **RUN**: per-cycle priority, highest first:
  1. `stall_i`=1: PC and all IF/ID registers hold. `flush_i` is ignored, because the ID instruction is not yet resolved.
  2. `flush_i`=1: PC←`target_i`; IF/ID←NOP (32'h0), pc4←0, valid←0.
  3. Otherwise: PC←PC+4; IF/ID inst←`inst_mem_i`, pc4←PC+4, valid←1.
  - Leaving RUN: `start_i`=0 returns to IDLE. Current PC is kept; IF/ID is bubbled.
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `target_i` is loaded unchanged; low bits are not forced.
- Reset mid-operation clears everything immediately, regardless of state.

## Timing
- Reset values: `pc_o`=0, `if_id_inst_o`=0, `if_id_pc4_o`=0, `if_id_valid_o`=0, state=IDLE, counters=0.
- Fetch latency: an instruction at `pc_o` in cycle N appears on `if_id_inst_o` in cycle N+1.
- Stall: registers are frozen for exactly the cycles where `stall_i`=1. Fetch resumes from the same PC on the cycle after deassertion.
- Flush: the target instruction appears on IF/ID two cycles after the flush edge. Exactly one bubble is inserted.
- Reset deassertion: first fetch of PC 0 is presented in the cycle the FSM enters RUN. Its IF/ID latch happens one cycle later.

## Configuration
- Macro `IF_PERF_CNT_EN`.
  - Defined: `stall_cnt_o` increments each RUN cycle with `stall_i`=1. `flush_cnt_o` increments each RUN cycle where `flush_i`=1 and `stall_i`=0. Both saturate at all-ones (no wrap). Both are held in IDLE and cleared only by reset.
  - Undefined: counters and their ports are absent; no other behaviour changes.

## Structure
- Shared package `cpu_pkg`: NOP constant (32'h0), PC reset value (32'h0), PC step (4), FSM state enum (IDLE, RUN).
- One sub-module, `pc_reg`: PC register with hold, load-target and increment. Async active-low reset.
- The IF/ID register, FSM and counters live in `if_id_stage`.

## Test plan
- **Reset**: assert `rst_i`=0 mid-RUN at PC=0x20 → all outputs 0 asynchronously, state IDLE. Release with `start_i`=1 → `pc_o` steps 0,4,8.
- **Sequential fetch**: memory returns 0x8C01_0000 at PC 0 → next cycle `if_id_inst_o`=0x8C01_0000, `if_id_pc4_o`=4, valid=1.
- **Stall**: 2-cycle `stall_i` at PC=0x10 → `pc_o` stays 0x10 and IF/ID unchanged for 2 cycles, then `pc_o`=0x14.
- **Flush**: `flush_i`=1 with `target_i`=0x40 → next cycle `pc_o`=0x40, IF/ID inst=0, valid=0. The following cycle latches the instruction at 0x40 with pc4=0x44.
- **Stall+flush together**: → stall wins; PC and IF/ID held. Flush takes effect on the first cycle with `stall_i`=0 if `flush_i` is still high.
- **Counters** (`IF_PERF_CNT_EN`, CNT_W=4): 20 stall cycles → `stall_cnt_o`=15 (saturated). 3 flushes → `flush_cnt_o`=3.
